pool_relu_stream: RTL

- Downstream stage of the conv_64_33_16_2 output stream.
- Consumes the signed y-stream of LEN words per input vector and applies non-overlapping 1-D max pooling (window = stride = POOL), with an optional ReLU clamp.
- Presents pooled results on a valid/ready output stream, buffered by a 2-entry FIFO.
- Marks the last pooled word of each vector with m_last_z.

---
 rtl/pool_relu_stream_pkg.sv | 18 +
 rtl/pool_fifo2.sv | 59 +++++
 rtl/pool_relu_stream.sv | 75 +++++++
 3 files changed

// File: rtl/pool_relu_stream_pkg.sv
// Shared types for the pooled output stream: sample width, default geometry, FIFO entry.
// No logic; signed max helper used by the pooling datapath.
package pool_relu_stream_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int LEN_DEF   = 32;
    localparam int POOL_DEF  = 2;

    typedef logic signed [WIDTH_DEF-1:0] sample_t;

    typedef struct packed {
        sample_t data;
        logic    last;
    } pool_entry_t;

    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (b > a) ? b : a;
    endfunction
endpackage

// File: rtl/pool_fifo2.sv
// Purpose: 2-entry valid/ready FIFO of pooled entries.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: in_rdy drops when both entries are occupied; head reads 0 when empty.
module pool_fifo2
    import pool_relu_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    output logic        in_rdy,
    input  pool_entry_t in_dat,
    output logic        out_vld,
    input  logic        out_rdy,
    output pool_entry_t out_dat
);
    pool_entry_t mem0_q, mem0_d, mem1_q, mem1_d;
    logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        push, pop;

    assign in_rdy  = (cnt_q != 2'd2);
    assign out_vld = (cnt_q != 2'd0);
    assign out_dat = !out_vld ? '0 : (rd_ptr_q ? mem1_q : mem0_q);
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            if (wr_ptr_q) mem1_d = in_dat;
            else          mem0_d = in_dat;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        // Simultaneous push and pop leaves the occupancy unchanged.
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (pop && !push) cnt_d = cnt_q - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/pool_relu_stream.sv
// Purpose: non-overlapping 1-D signed max pooling with optional ReLU over LEN-word vectors.
// Latency: window-closing sample at edge k appears at m_data_out_z after edge k.
// Backpressure: s_ready_y follows FIFO occupancy (<2) only; held low during reset.
module pool_relu_stream
    import pool_relu_stream_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int LEN    = LEN_DEF,
    parameter int POOL   = POOL_DEF,
    parameter int RELU   = 1,
    parameter int LOGLEN = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data_in_y,
    input  logic             s_valid_y,
    output logic             s_ready_y,
    output logic [WIDTH-1:0] m_data_out_z,
    output logic             m_valid_z,
    input  logic             m_ready_z,
    output logic             m_last_z
);
    logic [LOGLEN-1:0] win_idx_q, win_idx_d, elem_cnt_q, elem_cnt_d;
    sample_t           acc_q, acc_d, sample, mx, res;
    logic              accept, close, is_last, fifo_in_rdy;
    pool_entry_t       push_dat, head;

    assign sample    = s_data_in_y;
    assign s_ready_y = reset & fifo_in_rdy;
    assign accept    = s_valid_y & s_ready_y;
    assign is_last   = (elem_cnt_q == LOGLEN'(LEN - 1));
    assign close     = (win_idx_q == LOGLEN'(POOL - 1)) || is_last;
    assign mx        = (win_idx_q == '0) ? sample : smax(acc_q, sample);
    assign res       = (RELU != 0 && mx[WIDTH-1]) ? sample_t'(0) : mx;

    always_comb begin
        acc_d         = acc_q;
        win_idx_d     = win_idx_q;
        elem_cnt_d    = elem_cnt_q;
        push_dat.data = res;
        push_dat.last = is_last;
        if (accept) begin
            acc_d      = mx;
            win_idx_d  = close ? '0 : win_idx_q + 1'b1;
            // Wrapping here lets the next vector follow with no idle cycle.
            elem_cnt_d = is_last ? '0 : elem_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            win_idx_q  <= '0;
            elem_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            win_idx_q  <= win_idx_d;
            elem_cnt_q <= elem_cnt_d;
        end
    end

    pool_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .in_vld  (accept & close),
        .in_rdy  (fifo_in_rdy),
        .in_dat  (push_dat),
        .out_vld (m_valid_z),
        .out_rdy (m_ready_z),
        .out_dat (head)
    );

    assign m_data_out_z = head.data;
    assign m_last_z     = head.last;
endmodule
